// File: rtl/rh_gpv_vector_sequencer.sv
// Generic FIFO for the command queue. The head entry is read combinationally.
// Occupancy is registered and changes one edge after a push or pop.
// The FIFO drops a push while full and a pop while empty, so callers gate with full/empty.
module rh_gpv_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  output logic [W-1:0]             head_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full     = (level == (AW+1)'(DEPTH));
  assign empty    = (level == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end
endmodule

// Sequencer for queued vector commands: WRITE, DELAY, MATCH with timeout, and SAMPLE.
// A command executes one edge after it is queued. Responses are registered and appear
// the cycle after the deciding edge. cmd_ready is !full, and responses have no backpressure.
module rh_gpv_vector_sequencer #(
  parameter int                      VECTOR_WIDTH = 32,
  parameter int                      DEPTH        = 8,
  parameter int                      COUNT_WIDTH  = 16,
  parameter logic [VECTOR_WIDTH-1:0] RESET_VALUE  = '0,
  parameter int                      PW           = $clog2(VECTOR_WIDTH)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [PW-1:0]            cmd_spos,
  input  logic [PW:0]              cmd_size,
  input  logic [VECTOR_WIDTH-1:0]  cmd_data,
  input  logic [COUNT_WIDTH-1:0]   cmd_count,
  output logic [VECTOR_WIDTH-1:0]  vector,
  input  logic [VECTOR_WIDTH-1:0]  vector_in,
  output logic                     rsp_valid,
  output logic [VECTOR_WIDTH-1:0]  rsp_data,
  output logic                     rsp_timeout,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level
);
  typedef enum logic [1:0] {OP_WRITE = 2'd0, OP_DELAY = 2'd1, OP_MATCH = 2'd2, OP_SAMPLE = 2'd3} op_e;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DELAY = 2'd1, S_MATCH = 2'd2} state_e;

  typedef struct packed {
    logic [1:0]              op;
    logic [PW-1:0]           spos;
    logic [PW:0]             size;
    logic [VECTOR_WIDTH-1:0] dat;
    logic [COUNT_WIDTH-1:0]  count;
  } cmd_t;

  // Field bits past the top of the vector fall off the shift, so fields clip instead of wrapping.
  function automatic logic [VECTOR_WIDTH-1:0] field_mask(input logic [PW-1:0] spos, input logic [PW:0] size);
    logic [VECTOR_WIDTH-1:0] ones;
    ones = '1;
    return (ones >> (VECTOR_WIDTH - int'(size))) << spos;
  endfunction

  state_e                  state_q, state_d;
  cmd_t                    cmd_in, head;
  logic                    fifo_full, fifo_empty, pop;
  logic [PW-1:0]           cur_spos;
  logic [PW:0]             cur_size;
  logic [VECTOR_WIDTH-1:0] cur_dat;
  logic [COUNT_WIDTH-1:0]  cur_count, timer;
  logic [VECTOR_WIDTH-1:0] head_mask, cur_mask, vector_d, rsp_field;
  logic                    hit, expired, rsp_fire, rsp_to;

  assign cmd_in    = {cmd_op, cmd_spos, cmd_size, cmd_data, cmd_count};
  assign cmd_ready = !fifo_full;
  assign pop       = (state_q == S_IDLE) && !fifo_empty;
  assign busy      = (state_q != S_IDLE) || !fifo_empty;

  rh_gpv_fifo #(.W($bits(cmd_t)), .DEPTH(DEPTH)) u_cmd_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (cmd_valid),
    .push_dat (cmd_in),
    .pop      (pop),
    .head_dat (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (level)
  );

  assign head_mask = field_mask(head.spos, head.size);
  assign cur_mask  = field_mask(cur_spos, cur_size);
  assign hit       = (((vector_in ^ (cur_dat << cur_spos)) & cur_mask) == '0);
  assign expired   = (cur_count != '0) && (timer == cur_count - 1'b1);

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (pop && head.op == OP_DELAY && head.count != '0) state_d = S_DELAY;
        else if (pop && head.op == OP_MATCH)                state_d = S_MATCH;
      end
      S_DELAY: if (timer == COUNT_WIDTH'(1)) state_d = S_IDLE;
      S_MATCH: if (hit || expired)            state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    vector_d  = vector;
    rsp_fire  = 1'b0;
    rsp_to    = 1'b0;
    rsp_field = '0;
    if (pop && head.op == OP_WRITE)
      vector_d = (vector & ~head_mask) | ((head.dat << head.spos) & head_mask);
    if (pop && head.op == OP_SAMPLE) begin
      rsp_fire  = 1'b1;
      rsp_field = (vector_in & head_mask) >> head.spos;
    end
    // A compare that hits on the final timeout edge still reports a match.
    if (state_q == S_MATCH && (hit || expired)) begin
      rsp_fire  = 1'b1;
      rsp_to    = !hit;
      rsp_field = (vector_in & cur_mask) >> cur_spos;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vector      <= RESET_VALUE;
      rsp_valid   <= 1'b0;
      rsp_timeout <= 1'b0;
      rsp_data    <= '0;
      timer       <= '0;
      cur_spos    <= '0;
      cur_size    <= '0;
      cur_dat     <= '0;
      cur_count   <= '0;
    end else begin
      vector      <= vector_d;
      rsp_valid   <= rsp_fire;
      rsp_timeout <= rsp_to;
      if (rsp_fire) rsp_data <= rsp_field;
      if (pop) begin
        cur_spos  <= head.spos;
        cur_size  <= head.size;
        cur_dat   <= head.dat;
        cur_count <= head.count;
        // DELAY counts down from N. MATCH counts up the compares done so far.
        timer     <= (head.op == OP_DELAY) ? head.count : '0;
      end else if (state_q == S_DELAY) begin
        timer <= timer - 1'b1;
      end else if (state_q == S_MATCH) begin
        timer <= timer + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_rh_gpv_vector_sequencer.sv
// Bench for rh_gpv_vector_sequencer: table of WRITE/SAMPLE vectors plus timed DELAY, MATCH, full-FIFO and reset sequences.
module tb_rh_gpv_vector_sequencer;
  localparam logic [31:0] RV   = 32'h0300_0006;
  localparam logic [1:0]  OP_W = 2'd0;
  localparam logic [1:0]  OP_D = 2'd1;
  localparam logic [1:0]  OP_M = 2'd2;
  localparam logic [1:0]  OP_S = 2'd3;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_spos;
  logic [5:0]  cmd_size;
  logic [31:0] cmd_data;
  logic [15:0] cmd_count;
  logic [31:0] vector, vector_in, rsp_data;
  logic        rsp_valid, rsp_timeout, busy;
  logic [3:0]  level;

  always #5 clock = ~clock;

  rh_gpv_vector_sequencer #(
    .VECTOR_WIDTH(32), .DEPTH(8), .COUNT_WIDTH(16), .RESET_VALUE(RV)
  ) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_spos(cmd_spos), .cmd_size(cmd_size), .cmd_data(cmd_data),
    .cmd_count(cmd_count), .vector(vector), .vector_in(vector_in), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_timeout(rsp_timeout), .busy(busy), .level(level)
  );

  typedef struct {
    logic [1:0]  op;
    logic [4:0]  spos;
    logic [5:0]  size;
    logic [31:0] dat;
    logic [31:0] vin;
    logic [31:0] exp_vec;
    logic [31:0] exp_rsp;
  } vec_t;

  typedef struct packed {
    logic [31:0] dat;
    logic        tmo;
  } rsp_t;

  rsp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Holds the command until an edge where cmd_ready was high; returns the number of edges taken.
  task automatic push(input logic [1:0] op, input logic [4:0] spos, input logic [5:0] size,
                      input logic [31:0] dat, input logic [15:0] cnt, output int waited);
    logic acc;
    bit   done;
    cmd_valid = 1'b1; cmd_op = op; cmd_spos = spos; cmd_size = size;
    cmd_data = dat; cmd_count = cnt;
    waited = 0;
    done = 0;
    while (!done && waited < 300) begin
      acc = cmd_ready;
      tick();
      waited++;
      if (acc) done = 1;
    end
    cmd_valid = 1'b0;
    if (!done) begin
      checks++;
      $display("FAIL push_accept: command never accepted after %0d edges", waited);
    end
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 200 && busy; t++) tick();
    check("wait_idle_busy", busy, 0);
  endtask

  initial begin
    vec_t tbl[11];
    int   w;

    tbl[0]  = '{OP_W, 5'd4,  6'd8,  32'h0000_00A5, 32'h0,         32'h0300_0A56, 32'h0};
    tbl[1]  = '{OP_W, 5'd28, 6'd8,  32'h0000_00FF, 32'h0,         32'hF300_0A56, 32'h0};
    tbl[2]  = '{OP_W, 5'd0,  6'd0,  32'h0000_FFFF, 32'h0,         32'hF300_0A56, 32'h0};
    tbl[3]  = '{OP_W, 5'd0,  6'd32, 32'h1234_5678, 32'h0,         32'h1234_5678, 32'h0};
    tbl[4]  = '{OP_W, 5'd31, 6'd1,  32'h0000_0001, 32'h0,         32'h9234_5678, 32'h0};
    tbl[5]  = '{OP_W, 5'd8,  6'd4,  32'h0000_FFF3, 32'h0,         32'h9234_5378, 32'h0};
    tbl[6]  = '{OP_S, 5'd4,  6'd8,  32'h0,         32'hDEAD_BEEF, 32'h9234_5378, 32'h0000_00EE};
    tbl[7]  = '{OP_S, 5'd28, 6'd8,  32'h0,         32'hDEAD_BEEF, 32'h9234_5378, 32'h0000_000D};
    tbl[8]  = '{OP_S, 5'd0,  6'd0,  32'h0,         32'hDEAD_BEEF, 32'h9234_5378, 32'h0};
    tbl[9]  = '{OP_S, 5'd0,  6'd32, 32'h0,         32'hDEAD_BEEF, 32'h9234_5378, 32'hDEAD_BEEF};
    tbl[10] = '{OP_S, 5'd16, 6'd16, 32'h0,         32'hDEAD_BEEF, 32'h9234_5378, 32'h0000_DEAD};

    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_spos = '0; cmd_size = '0;
    cmd_data = '0; cmd_count = '0; vector_in = '0;

    fork
      forever begin
        rsp_t e;
        @(negedge clock);
        if (rsp_valid) begin
          if (sb.size() == 0) begin
            checks++;
            $display("FAIL rsp_unexpected: rsp_valid with data 0x%0h timeout %0d, none expected", rsp_data, rsp_timeout);
          end else begin
            e = sb.pop_front();
            check("rsp_data", rsp_data, e.dat);
            check("rsp_timeout", rsp_timeout, e.tmo);
          end
        end
      end
      begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
      end
    join_none

    repeat (3) tick();
    reset = 1'b0;
    check("rst_vector", vector, RV);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_timeout", rsp_timeout, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_busy", busy, 0);
    check("rst_level", level, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    tick();

    for (int i = 0; i < 11; i++) begin
      vector_in = tbl[i].vin;
      if (tbl[i].op == OP_S) sb.push_back('{dat: tbl[i].exp_rsp, tmo: 1'b0});
      push(tbl[i].op, tbl[i].spos, tbl[i].size, tbl[i].dat, 16'd0, w);
      wait_idle();
      check($sformatf("tbl%0d_rsp_valid", i), rsp_valid, (tbl[i].op == OP_S));
      check($sformatf("tbl%0d_vector", i), vector, tbl[i].exp_vec);
    end

    // DELAY 5: the following WRITE lands 6 edges after the DELAY pop edge.
    vector_in = '0;
    push(OP_D, 5'd0, 6'd0, 32'h0, 16'd5, w);
    push(OP_W, 5'd0, 6'd1, 32'h1, 16'd0, w);
    for (int k = 1; k <= 6; k++) begin
      tick();
      check($sformatf("delay_vec0_e%0d", k), vector[0], (k == 6));
      if (k < 6) check($sformatf("delay_busy_e%0d", k), busy, 1);
    end
    check("delay_vector", vector, 32'h9234_5379);

    // Back-to-back WRITEs: one update per edge, first visible one edge after acceptance.
    push(OP_W, 5'd0, 6'd8, 32'h11, 16'd0, w);
    check("b2b_latency", vector, 32'h9234_5379);
    push(OP_W, 5'd8, 6'd8, 32'h22, 16'd0, w);
    check("b2b_w1", vector, 32'h9234_5311);
    push(OP_W, 5'd16, 6'd8, 32'h33, 16'd0, w);
    check("b2b_w2", vector, 32'h9234_2211);
    tick();
    check("b2b_w3", vector, 32'h9233_2211);
    wait_idle();

    // MATCH that succeeds on the third compare.
    vector_in = 32'hABCD_EF00;
    sb.push_back('{dat: 32'h9, tmo: 1'b0});
    push(OP_M, 5'd0, 6'd4, 32'h0000_00F9, 16'd10, w);
    repeat (3) tick();
    check("m_hit_pending", rsp_valid, 0);
    vector_in = 32'hABCD_EF09;
    tick();
    check("m_hit_valid", rsp_valid, 1);
    check("m_hit_tmo", rsp_timeout, 0);
    wait_idle();

    // MATCH that times out after 10 compares and reports the last sampled field.
    vector_in = 32'h0000_0005;
    sb.push_back('{dat: 32'h5, tmo: 1'b1});
    push(OP_M, 5'd0, 6'd4, 32'h9, 16'd10, w);
    repeat (10) tick();
    check("m_to_pending", rsp_valid, 0);
    tick();
    check("m_to_valid", rsp_valid, 1);
    check("m_to_tmo", rsp_timeout, 1);
    wait_idle();

    // MATCH that hits on the same edge its timeout expires: the match wins.
    vector_in = '0;
    sb.push_back('{dat: 32'hC, tmo: 1'b0});
    push(OP_M, 5'd8, 6'd4, 32'hC, 16'd3, w);
    repeat (3) tick();
    check("m_last_pending", rsp_valid, 0);
    vector_in = 32'h0000_0C00;
    tick();
    check("m_last_valid", rsp_valid, 1);
    check("m_last_tmo", rsp_timeout, 0);
    wait_idle();

    // Fill the FIFO behind DELAY 20. The ninth command waits for the first pop.
    vector_in = '0;
    push(OP_D, 5'd0, 6'd0, 32'h0, 16'd20, w);
    for (int k = 1; k <= 8; k++) push(OP_W, 5'd0, 6'd32, 32'h1111_1111 * k, 16'd0, w);
    check("fill_level", level, 8);
    check("fill_ready", cmd_ready, 0);
    check("fill_busy", busy, 1);
    push(OP_W, 5'd0, 6'd32, 32'h9999_9999, 16'd0, w);
    check("fill_wait_edges", w, 15);
    check("fill_order_w2", vector, 32'h2222_2222);
    for (int k = 3; k <= 9; k++) begin
      tick();
      check($sformatf("fill_order_w%0d", k), vector, 32'h1111_1111 * k);
    end
    wait_idle();

    // Reset during a MATCH with three queued commands aborts everything silently.
    vector_in = '0;
    push(OP_M, 5'd0, 6'd4, 32'h9, 16'd0, w);
    push(OP_W, 5'd0, 6'd32, 32'hAAAA_5555, 16'd0, w);
    push(OP_W, 5'd0, 6'd32, 32'h5555_AAAA, 16'd0, w);
    push(OP_W, 5'd0, 6'd32, 32'h0F0F_F0F0, 16'd0, w);
    check("abort_level_pre", level, 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_level", level, 0);
    check("abort_ready", cmd_ready, 1);
    check("abort_busy", busy, 0);
    check("abort_vector", vector, RV);
    check("abort_rsp_valid", rsp_valid, 0);
    repeat (10) tick();
    check("abort_vector_hold", vector, RV);
    check("abort_busy_hold", busy, 0);

    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/rh_gpv_vector_sequencer.md
# rh_gpv_vector_sequencer

Parametrised, cycle-accurate RTL successor to the general-purpose vector (GPV) interface. It accepts a queued stream of vector commands: field write, delay, wait-for-match with timeout, and field sample. It drives a bit-vector output and observes a bit-vector input on a single clock. It sits between a command source (bench sequencer, CPU-mapped regs or script engine) and DUT GPIO-style pins, replacing per-bit testbench functions with ordered, timed hardware behaviour.

## Interface
Parameters:
- VECTOR_WIDTH, 32, width of `vector` and `vector_in` (1..1024).
- DEPTH, 8, command FIFO entries (power of 2, ≥2).
- COUNT_WIDTH, 16, width of delay/timeout counter.
- RESET_VALUE, '0, value loaded into `vector` on reset.
- PW, $clog2(VECTOR_WIDTH), derived bit-position width (not overridden).

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO can accept (= !full).
- cmd_op  in  2  0 WRITE, 1 DELAY, 2 MATCH, 3 SAMPLE.
- cmd_spos  in  PW  field start bit.
- cmd_size  in  PW+1  field width, 0..VECTOR_WIDTH.
- cmd_data  in  VECTOR_WIDTH  write/match value, LSB-aligned.
- cmd_count  in  COUNT_WIDTH  delay cycles (DELAY) or timeout cycles (MATCH, 0 = none).
- vector  out  VECTOR_WIDTH  driven vector, registered.
- vector_in  in  VECTOR_WIDTH  observed vector (DUT-driven).
- rsp_valid  out  1  one-cycle response pulse.
- rsp_data  out  VECTOR_WIDTH  captured field, LSB-aligned, upper bits 0.
- rsp_timeout  out  1  qualifies rsp_valid: MATCH expired.
- busy  out  1  FSM not IDLE or FIFO non-empty.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- Push on `cmd_valid && cmd_ready`; no bypass, full FIFO rejects even when popping same cycle.
- FSM states IDLE, DELAY, MATCH. In IDLE with FIFO non-empty: pop head and execute.
- Field = bits [spos .. spos+size-1]; bits at index ≥ VECTOR_WIDTH are clipped (no wrap). size 0 = no-op for WRITE/SAMPLE (SAMPLE still responds, rsp_data 0); MATCH with size 0 matches immediately.
- WRITE: `vector` field ← cmd_data[size-1:0] at pop edge; other bits held; stays IDLE (one WRITE per cycle).
- DELAY: count N>0 → DELAY state for exactly N cycles, then IDLE; N=0 completes at pop edge as no-op.
- MATCH: enter MATCH, timer cleared. Each edge in MATCH compare `vector_in` field with cmd_data field. Equal → rsp_valid, rsp_data = field, rsp_timeout 0, IDLE. If count>0 and count edges elapse unmatched → rsp_valid, rsp_timeout 1, rsp_data = last sampled field, IDLE. Match on the final edge wins over timeout.
- SAMPLE: at pop edge capture `vector_in` field into rsp_data, rsp_valid next cycle, stays IDLE.
- Responses have no backpressure; ordering matches command order.
- Reset: FIFO flushed, level 0, cmd_ready 1 (from next cycle), FSM IDLE, vector = RESET_VALUE, rsp_valid 0, rsp_timeout 0, rsp_data 0, busy 0. Reset mid-DELAY/MATCH aborts without response.

## Timing
- Command accepted at edge E0 into empty, idle sequencer: popped at E1; WRITE visible on `vector` after E1.
- Back-to-back WRITEs: one `vector` update per cycle.
- DELAY N at pop edge Ep: next command pops at Ep+N+1.
- MATCH popped at Ep: first compare at Ep+1; rsp_valid high for the cycle after the deciding edge.
- SAMPLE popped at Ep samples vector_in at Ep; rsp_valid high during cycle Ep..Ep+1.
- cmd_ready, level, busy are registered from FIFO state; level updates one edge after push/pop.

## Test plan
- Reset then WRITE spos=4 size=8 data=0xA5 → vector = RESET_VALUE with bits[11:4]=0xA5 one edge after pop, other bits unchanged.
- WRITE spos=28 size=8 data=0xFF (VECTOR_WIDTH=32) → only bits[31:28] set; no wrap into bits[3:0].
- DELAY 5 then WRITE bit0=1 → vector[0] rises exactly 6 edges after the DELAY pop edge; busy high throughout.
- MATCH spos=0 size=4 data=0x9 count=10, vector_in[3:0]=0x9 driven at cycle 3 → rsp_valid, rsp_timeout 0, rsp_data 0x9; same with no drive → rsp_timeout 1 after 10 cycles.
- Push 9 commands with DEPTH=8 while a DELAY 20 executes → cmd_ready low at level 8, ninth accepted only after a pop; all executed in order.
- Assert reset during MATCH with 3 queued commands → no rsp_valid, level 0, vector = RESET_VALUE next cycle.
